// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// State encoding, divider step count and counter width.
// Also holds the conditional two's-complement helper used by sign fix-up.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One quotient bit per cycle for a 32-bit divide.
  localparam int DIV_STEPS = 32;
  // Wide enough to hold DIV_STEPS.
  localparam int CNT_W     = 6;

  // Negate v when neg is set, otherwise pass it through.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Latency: start edge, then 32 step cycles; done is high in the 32nd step cycle.
// quotient/remainder are the result of the current step, valid while done is high.
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [32:0]      shifted;
  logic [31:0]      diff;
  logic             ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // With a zero divisor every step "fits", giving all-ones and rem = dividend.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    ge        = (shifted >= {1'b0, dvs_q});
    diff      = shifted[31:0] - dvs_q;
    quotient  = {quo_q[30:0], ge};
    remainder = ge ? diff : shifted[31:0];
  end

  assign done = (cnt_q == CNT_W'(1));

  // Load operands on start, then advance one step per cycle until the count runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(DIV_STEPS);
    end else if (cnt_q != '0) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: sequences pipelined multiply and iterative divide, handles mthi/mtlo.
// Latency: multiply MUL_LATENCY cycles after accept, divide 32 cycles after accept.
// Stalls the issuing EX instruction until HI/LO are written; cancel aborts at once.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_CYCLES  = DIV_STEPS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic        rd_hilo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_advance,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             op;
  logic             mul_op;
  logic             div_op;
  logic             accept;
  logic [63:0]      ext_a;
  logic [63:0]      ext_b;
  logic [63:0]      prod;
  logic [MUL_LATENCY-1:0][63:0] mul_pipe;
  logic [31:0]      div_q;
  logic [31:0]      div_r;
  logic             div_done;
  logic             unused_rd_hilo;

  // HI/LO reads come straight off the hi/lo ports; the read strobe only matters
  // through the op/stall terms driven by the decoder.
  assign unused_rd_hilo = rd_hilo;

  assign mul_op = is_mult | is_multu;
  assign div_op = is_div | is_divu;
  assign op     = mul_op | div_op;
  assign accept = (state == ST_IDLE) & req_valid & op & ~cancel;

  assign stall = req_valid & ((state == ST_MUL) | (state == ST_DIV) |
                              ((state == ST_IDLE) & op));
  assign busy  = (state != ST_IDLE);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign ext_a = {{32{is_mult & src_a[31]}}, src_a};
  assign ext_b = {{32{is_mult & src_b[31]}}, src_b};
  assign prod  = ext_a * ext_b;

  // Product pipeline: stage 0 captures the accept-cycle product, later stages
  // shift it so the last stage holds it exactly MUL_LATENCY cycles after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_pipe <= '0;
    end else begin
      mul_pipe[0] <= prod;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        mul_pipe[i] <= mul_pipe[i-1];
      end
    end
  end

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept & div_op),
    .abort     (cancel),
    .dividend  (neg_if(src_a, is_div & src_a[31])),
    .divisor   (neg_if(src_b, is_div & src_b[31])),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  // Sequencer: accept, count down, write HI/LO, hold in DONE until EX advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (cancel) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid & op) begin
            state <= mul_op ? ST_MUL : ST_DIV;
            cnt   <= mul_op ? CNT_W'(MUL_LATENCY) : CNT_W'(DIV_CYCLES);
            neg_q <= is_div & (src_a[31] ^ src_b[31]);
            neg_r <= is_div & src_a[31];
          end else if (req_valid) begin
            if (hi_wen) hi <= src_a;
            if (lo_wen) lo <= src_a;
          end
        end
        ST_MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi    <= mul_pipe[MUL_LATENCY-1][63:32];
            lo    <= mul_pipe[MUL_LATENCY-1][31:0];
            state <= ST_DONE;
          end
        end
        ST_DIV: begin
          cnt <= cnt - CNT_W'(1);
          if (div_done) begin
            hi    <= neg_if(div_r, neg_r);
            lo    <= neg_if(div_q, neg_q);
            state <= ST_DONE;
          end
        end
        default: begin
          if (ex_advance) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer and owner of the HI/LO register pair. It accepts the multiply/divide/move-to-HI/LO strobes decoded in ID and carried into EX, and runs a pipelined multiplier or a 32-step iterative divider. It holds the issuing instruction in EX with a stall until HI/LO are written. It also supplies HI/LO to mfhi/mflo and the mul product path.

Parameters:
MUL_LATENCY, 2, number of busy cycles after accept for a multiply; legal range 1..4.
DIV_CYCLES, 32, divider iteration cycles; fixed at 32 and only overridable in simulation.

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  EX holds a valid instruction that is not being flushed
is_mult  in  1  signed multiply (mult or mul)
is_multu  in  1  unsigned multiply
is_div  in  1  signed divide
is_divu  in  1  unsigned divide
hi_wen  in  1  mthi
lo_wen  in  1  mtlo
rd_hilo  in  1  EX instruction reads HI/LO (mfhi, mflo, mul result)
src_a  in  32  rs operand (dividend, multiplicand, mthi/mtlo data)
src_b  in  32  rt operand
ex_advance  in  1  EX instruction moves to MEM this cycle
cancel  in  1  exception/eret flush of EX and older stages
stall  out  1  hold EX (combinational)
busy  out  1  state is not IDLE
hi  out  32  HI register
lo  out  32  LO register (also the mul GPR result)

Behaviour:
- Reset (asynchronous): state IDLE, hi = 0, lo = 0, counter = 0, busy = 0. Asserting reset mid-operation aborts the operation.
- op = is_mult | is_multu | is_div | is_divu. At most one strobe is set per cycle; if more than one is set, the result is undefined.
- States and transitions:
  - IDLE to MUL or DIV: when req_valid & op & ~cancel. Latch src_a, src_b and signedness; load the counter with MUL_LATENCY or DIV_CYCLES.
  - MUL/DIV: decrement the counter each cycle. At count 1, write HI/LO on the edge and go to DONE.
  - DONE: hold until ex_advance = 1, then go to IDLE. No new accept while in DONE, because the same instruction is still in EX.
- stall = req_valid & (state == MUL | state == DIV | (state == IDLE & op)). In DONE, stall = 0.
- Latency, with accept in cycle T:
  - Multiply: stall is high for cycles T..T+MUL_LATENCY. HI/LO are written at the end of cycle T+MUL_LATENCY.
  - Divide: stall is high for cycles T..T+32 (33 cycles). HI/LO are written at the end of cycle T+32.
- Multiply: 64-bit product of the sign- or zero-extended operands; hi = product[63:32], lo = product[31:0].
- Divide: take operand magnitudes and run an unsigned restoring divide.
  - Quotient is negated if the operand signs differ and the op is signed.
  - Remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Divide boundary cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = |dividend|, then the sign fixes above are applied.
  - 0x80000000 / -1: lo = 0x80000000, hi = 0.
- mthi/mtlo: in IDLE with req_valid & ~cancel, the register is written with src_a at the next edge. No stall. A pending mthi/mtlo in MUL/DIV waits on stall.
- rd_hilo: reads the hi/lo outputs directly. It stalls only through the stall rule above; a rd_hilo instruction that reaches EX while busy sees stall = 1.
- cancel has highest priority. From any state, go to IDLE next edge with no HI/LO write and the counter cleared. A request in the same cycle is not accepted. cancel in the completion cycle suppresses the write.
- busy reflects the state register only.

Decomposition:
- Shared header muldiv.vh: state encodings (IDLE, MUL, DIV, DONE), DIV_CYCLES, counter width.
- One sub-module, div_iter: unsigned radix-2 restoring divider with start, abort, and a 32-cycle done pulse.
- Sign pre-processing and post-fix live in muldiv_ctrl. The multiply uses an inferred * with MUL_LATENCY register stages.

Test Plan:
1. mult src_a = 0xFFFFFFFB (-5), src_b = 7, MUL_LATENCY = 2 -> stall high 3 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFDD.
2. multu 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
3. Signed and overflow divides:
   - div -7 / 2 -> stall high 33 cycles; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
   - div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
4. divu 7 / 0 -> lo = 0xFFFFFFFF, hi = 7. Separately: cancel in cycle T+10 of a divide -> IDLE next cycle, stall = 0, hi/lo unchanged.
5. Completion and mthi:
   - Hold ex_advance = 0 for 3 cycles in DONE with req_valid/is_div still high -> no re-accept, stall = 0, hi/lo stable.
   - Then mthi src_a = 0x1234 from IDLE -> hi = 0x1234 after one edge, stall = 0 throughout.
6. Assert reset in cycle T+5 of a multu -> hi = lo = 0 and busy = 0 immediately (asynchronously). After release, a new mult completes normally.
